cardinal_nic: RTL and testbench
===============================

CARDINAL_NIC -- requirements
Module: cardinal_nic

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have port addr, input, 2 bits [0:1]: CPU register select. 00 = input buffer, 01 = input status, 10 = output buffer, 11 = output status.
REQ-004 The block SHALL have port d_in, input, 64 bits [0:63]: CPU write data.
REQ-005 The block SHALL have port d_out, output, 64 bits [0:63]: CPU read data.
REQ-006 The block SHALL have port nicEn, input, 1 bit: CPU access enable.
REQ-007 The block SHALL have port nicWrEn, input, 1 bit: 1 = write, 0 = read; valid only with nicEn.
REQ-008 The block SHALL have port net_so, output, 1 bit: send strobe to the router.
REQ-009 The block SHALL have port net_ro, input, 1 bit: router ready to accept.
REQ-010 The block SHALL have port net_do, output, 64 bits [0:63]: packet to the router.
REQ-011 The block SHALL have port net_polarity, input, 1 bit: router's current even/odd phase.
REQ-012 The block SHALL have port net_si, input, 1 bit: router send strobe into the NIC.
REQ-013 The block SHALL have port net_ri, output, 1 bit: NIC ready to accept a packet.
REQ-014 The block SHALL have port net_di, input, 64 bits [0:63]: packet from the router.

Function
REQ-015 The output channel SHALL be a 2-entry FIFO with 1-bit read/write pointers (wrapping 1->0) and a 2-bit count (0..2); out_full = (count==2).
REQ-016 The input channel SHALL be a 1-entry buffer with flag in_full.
REQ-017 A CPU write (nicEn=1, nicWrEn=1, addr=10) with out_full=0 SHALL store d_in at the write pointer and increment the count at that edge; with out_full=1 the write SHALL be dropped with no state change.
REQ-018 CPU writes to addr 00, 01 or 11 SHALL be ignored.
REQ-019 d_out SHALL be combinational: addr 00 -> input buffer; 01 -> {63'b0, in_full}; 11 -> {63'b0, out_full} (status in bit 63); 10 or nicEn=0 or nicWrEn=1 -> 64'b0.
REQ-020 A CPU read of addr 00 with in_full=1 SHALL clear in_full at that edge; with in_full=0 it SHALL be a no-op.
REQ-021 net_do SHALL always present the FIFO head entry, and SHALL be 0 when count==0.
REQ-022 net_so SHALL equal (count!=0) & net_ro & (head[0]==net_polarity), where bit 0 is the VC bit; combinational, no added latency.
REQ-023 At each edge with net_so=1, the head SHALL be popped: read pointer advanced, count decremented.
REQ-024 A simultaneous push and pop in one cycle SHALL leave the count unchanged and move both pointers; push acceptance SHALL use the pre-edge out_full.
REQ-025 net_ri SHALL equal ~in_full & ~reset.
REQ-026 net_si=1 while net_ri=1 SHALL latch net_di and set in_full at that edge; net_si while net_ri=0 SHALL be ignored.
REQ-027 A CPU read of addr 00 and an arriving net_si in the same cycle cannot both take effect (net_ri=0 when in_full=1); the read SHALL take precedence.
REQ-028 Packets SHALL be delivered in FIFO order with no reordering or duplication.

Reset
REQ-029 While reset=1: pointers, count and in_full SHALL be 0; both buffers SHALL be cleared to 0; net_so=0, net_ri=0, net_do=0; d_out SHALL follow REQ-019 (status reads 0).
REQ-030 A reset asserted mid-operation SHALL discard all buffered packets immediately and asynchronously.
REQ-031 After reset deasserts, net_ri=1 SHALL hold from the first cycle.

Verification
REQ-032 Push 64'h8000_0000_0000_00AA at addr 10 with net_ro=1 and net_polarity=1 -> net_so=1 on the next cycle with net_do=64'h8000_0000_0000_00AA; FIFO empty after that edge.
REQ-033 Same packet with net_polarity=0 -> net_so stays 0 until polarity toggles to 1, then the packet is sent once.
REQ-034 With net_ro=0, push 3 packets A, B, C -> addr 11 reads 1 after B; C is dropped; after raising net_ro with matching polarity, A then B are sent and C never appears.
REQ-035 Router sends 64'h1234 with net_si=1 -> net_ri=0 next cycle and addr 01 reads 1; CPU reads addr 00 -> 64'h1234, then in_full=0 and net_ri=1.
REQ-036 Count=1 and the head is being sent while the CPU pushes in the same cycle -> count remains 1 and the new packet becomes the head.
REQ-037 Assert reset with count=2 and in_full=1 -> all flags 0 and net_so=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cardinal_nic_if.sv
// CPU register port and router link of the cardinal NIC, grouped as one bundle.
// slave = NIC side, master = CPU/router side driving the NIC.
interface cardinal_nic_if;
  logic [0:1]  addr;
  logic [0:63] d_in;
  logic [0:63] d_out;
  logic        nicEn;
  logic        nicWrEn;
  logic        net_so;
  logic        net_ro;
  logic [0:63] net_do;
  logic        net_polarity;
  logic        net_si;
  logic        net_ri;
  logic [0:63] net_di;

  modport slave (
    input  addr, d_in, nicEn, nicWrEn, net_ro, net_polarity, net_si, net_di,
    output d_out, net_so, net_do, net_ri
  );

  modport master (
    output addr, d_in, nicEn, nicWrEn, net_ro, net_polarity, net_si, net_di,
    input  d_out, net_so, net_do, net_ri
  );
endinterface

// File: rtl/cardinal_nic.sv
// Network interface: 2-deep CPU->router output FIFO and a 1-deep router->CPU input buffer.
// Bit 0 of every packet (MSB, big-endian numbering) is the virtual-channel bit.
module cardinal_nic (
  input  logic           clk,
  input  logic           reset,
  cardinal_nic_if.slave  nic
);

  logic [0:63] outBuf [2];
  logic        wrPtr;
  logic        rdPtr;
  logic [1:0]  outCount;
  logic [0:63] inBuf;
  logic        inFull;

  logic        outFull;
  logic        outEmpty;
  logic [0:63] head;
  logic        cpuRead;
  logic        push;
  logic        pop;
  logic        netRi;
  logic        inAccept;
  logic        inClear;

  assign outFull  = (outCount == 2'd2);
  assign outEmpty = (outCount == 2'd0);
  assign head     = outBuf[rdPtr];

  assign cpuRead  = nic.nicEn & ~nic.nicWrEn;
  assign push     = nic.nicEn & nic.nicWrEn & (nic.addr == 2'b10) & ~outFull;
  assign pop      = ~outEmpty & nic.net_ro & (head[0] == nic.net_polarity);

  // A CPU drain of the input buffer wins; netRi is already low in that case anyway.
  assign netRi    = ~inFull & ~reset;
  assign inClear  = cpuRead & (nic.addr == 2'b00) & inFull;
  assign inAccept = nic.net_si & netRi;

  assign nic.net_so = pop;
  assign nic.net_do = outEmpty ? 64'd0 : head;
  assign nic.net_ri = netRi;

  always_comb begin
    nic.d_out = 64'd0;
    if (cpuRead) begin
      case (nic.addr)
        2'b00:   nic.d_out = inBuf;
        2'b01:   nic.d_out = {63'd0, inFull};
        2'b11:   nic.d_out = {63'd0, outFull};
        default: nic.d_out = 64'd0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outBuf[0] <= 64'd0;
      outBuf[1] <= 64'd0;
      wrPtr     <= 1'b0;
      rdPtr     <= 1'b0;
      outCount  <= 2'd0;
    end else begin
      if (push) begin
        outBuf[wrPtr] <= nic.d_in;
        wrPtr         <= ~wrPtr;
      end
      if (pop) begin
        rdPtr <= ~rdPtr;
      end
      case ({push, pop})
        2'b10:   outCount <= outCount + 2'd1;
        2'b01:   outCount <= outCount - 2'd1;
        default: outCount <= outCount;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inBuf  <= 64'd0;
      inFull <= 1'b0;
    end else if (inClear) begin
      inFull <= 1'b0;
    end else if (inAccept) begin
      inBuf  <= nic.net_di;
      inFull <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cardinal_nic.sv
// Bench for cardinal_nic: directed scenarios plus random traffic against a queue-based model.
module tb_cardinal_nic;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  cardinal_nic_if nicBus ();

  cardinal_nic dut (
    .clk   (clk),
    .reset (reset),
    .nic   (nicBus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a bounded queue for the outbound side, a flag+word for inbound.
  logic [0:63] outQ [$];
  logic [0:63] inBufM;
  logic        inFullM;

  task automatic chkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    outQ.delete();
    inBufM  = 64'd0;
    inFullM = 1'b0;
  endtask

  // Drive one cycle of inputs, check every output, then advance the model past the edge.
  task automatic step(input logic en, input logic wr, input logic [1:0] a,
                      input logic [63:0] d, input logic ro, input logic pol,
                      input logic si, input logic [63:0] di);
    logic [63:0] expDout;
    logic        expSo;
    logic        pushOk;
    @(negedge clk);
    nicBus.nicEn        = en;
    nicBus.nicWrEn      = wr;
    nicBus.addr         = a;
    nicBus.d_in         = d;
    nicBus.net_ro       = ro;
    nicBus.net_polarity = pol;
    nicBus.net_si       = si;
    nicBus.net_di       = di;
    #1;
    expDout = 64'd0;
    if (en && !wr) begin
      if (a == 2'd0) expDout = inBufM;
      else if (a == 2'd1) expDout = {63'd0, inFullM};
      else if (a == 2'd3) expDout = {63'd0, outQ.size() == 2};
    end
    expSo = (outQ.size() != 0) && ro && (outQ[0][0] == pol);
    chkVal("d_out", nicBus.d_out, expDout);
    chkVal("net_so", {63'd0, nicBus.net_so}, {63'd0, expSo});
    chkVal("net_do", nicBus.net_do, (outQ.size() != 0) ? outQ[0] : 64'd0);
    chkVal("net_ri", {63'd0, nicBus.net_ri}, {63'd0, !inFullM});
    pushOk = en && wr && (a == 2'd2) && (outQ.size() < 2);
    if (expSo) void'(outQ.pop_front());
    if (pushOk) outQ.push_back(d);
    if (en && !wr && a == 2'd0 && inFullM) inFullM = 1'b0;
    else if (si && !inFullM) begin
      inFullM = 1'b1;
      inBufM  = di;
    end
  endtask

  task automatic idle(input logic ro, input logic pol);
    step(1'b0, 1'b0, 2'd0, 64'd0, ro, pol, 1'b0, 64'd0);
  endtask

  task automatic push(input logic [63:0] d, input logic ro, input logic pol);
    step(1'b1, 1'b1, 2'd2, d, ro, pol, 1'b0, 64'd0);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    modelReset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  localparam logic [63:0] PKT_A = 64'h8000_0000_0000_00AA;
  localparam logic [63:0] PKT_B = 64'h8000_0000_0000_00BB;
  localparam logic [63:0] PKT_C = 64'h8000_0000_0000_00CC;
  localparam logic [63:0] PKT_D = 64'h8000_0000_0000_00DD;

  initial begin
    vectors      = 0;
    miscompares  = 0;
    nicBus.nicEn = 1'b0; nicBus.nicWrEn = 1'b0; nicBus.addr = 2'd0; nicBus.d_in = 64'd0;
    nicBus.net_ro = 1'b0; nicBus.net_polarity = 1'b0; nicBus.net_si = 1'b0; nicBus.net_di = 64'd0;
    reset = 1'b1;
    modelReset();
    #2;
    chkVal("rst_net_ri", {63'd0, nicBus.net_ri}, 64'd0);
    chkVal("rst_net_so", {63'd0, nicBus.net_so}, 64'd0);
    chkVal("rst_net_do", nicBus.net_do, 64'd0);
    doReset();

    // Immediate send with matching polarity
    idle(1'b1, 1'b1);
    push(PKT_A, 1'b1, 1'b1);
    idle(1'b1, 1'b1);
    chkVal("send_so", {63'd0, nicBus.net_so}, 64'd1);
    chkVal("send_do", nicBus.net_do, PKT_A);
    idle(1'b1, 1'b1);
    chkVal("send_empty", {63'd0, nicBus.net_so}, 64'd0);

    // Polarity mismatch holds the packet until the phase matches
    push(PKT_A, 1'b1, 1'b0);
    repeat (3) idle(1'b1, 1'b0);
    idle(1'b1, 1'b1);
    chkVal("pol_send", {63'd0, nicBus.net_so}, 64'd1);
    idle(1'b1, 1'b1);
    chkVal("pol_once", {63'd0, nicBus.net_so}, 64'd0);

    // Full FIFO drops the third write
    push(PKT_A, 1'b0, 1'b1);
    push(PKT_B, 1'b0, 1'b1);
    step(1'b1, 1'b0, 2'd3, 64'd0, 1'b0, 1'b1, 1'b0, 64'd0);
    chkVal("full_status", nicBus.d_out, 64'd1);
    push(PKT_C, 1'b0, 1'b1);
    idle(1'b1, 1'b1);
    chkVal("drain_a", nicBus.net_do, PKT_A);
    idle(1'b1, 1'b1);
    chkVal("drain_b", nicBus.net_do, PKT_B);
    idle(1'b1, 1'b1);
    chkVal("drop_c", {63'd0, nicBus.net_so}, 64'd0);

    // Inbound packet round trip
    step(1'b0, 1'b0, 2'd0, 64'd0, 1'b0, 1'b0, 1'b1, 64'h1234);
    step(1'b1, 1'b0, 2'd1, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0);
    chkVal("in_status", nicBus.d_out, 64'd1);
    chkVal("in_ri_low", {63'd0, nicBus.net_ri}, 64'd0);
    step(1'b1, 1'b0, 2'd0, 64'd0, 1'b0, 1'b0, 1'b1, 64'h5555);
    chkVal("in_data", nicBus.d_out, 64'h1234);
    idle(1'b0, 1'b0);
    chkVal("in_ri_high", {63'd0, nicBus.net_ri}, 64'd1);

    // Simultaneous push and pop at count 1
    push(PKT_A, 1'b0, 1'b1);
    push(PKT_D, 1'b1, 1'b1);
    step(1'b1, 1'b0, 2'd3, 64'd0, 1'b0, 1'b1, 1'b0, 64'd0);
    chkVal("pp_count", nicBus.d_out, 64'd0);
    chkVal("pp_head", nicBus.net_do, PKT_D);

    // Asynchronous reset with both buffers occupied
    push(PKT_B, 1'b0, 1'b1);
    step(1'b0, 1'b0, 2'd0, 64'd0, 1'b0, 1'b1, 1'b1, 64'hBEEF);
    step(1'b1, 1'b0, 2'd3, 64'd0, 1'b1, 1'b1, 1'b0, 64'd0);
    #2;
    reset = 1'b1;
    modelReset();
    #1;
    chkVal("arst_so", {63'd0, nicBus.net_so}, 64'd0);
    chkVal("arst_do", nicBus.net_do, 64'd0);
    chkVal("arst_ri", {63'd0, nicBus.net_ri}, 64'd0);
    chkVal("arst_full", nicBus.d_out, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    idle(1'b0, 1'b0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic        en, wr, ro, pol, si;
      logic [1:0]  a;
      logic [63:0] d, di;
      en  = ($urandom_range(0, 9) < 7);
      wr  = $urandom_range(0, 1);
      a   = 2'($urandom_range(0, 3));
      d   = {$urandom, $urandom};
      ro  = ($urandom_range(0, 9) < 6);
      pol = $urandom_range(0, 1);
      si  = ($urandom_range(0, 9) < 3);
      di  = {$urandom, $urandom};
      step(en, wr, a, d, ro, pol, si, di);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
